// File: rtl/comc_loader.sv
// Collects four decimal digits plus an op code into a held frame for the COMC stage.
// Optional range checking (clamp to 9, sticky err) is enabled by defining COMC_LOADER_RANGE_CHECK_EN.
module comc_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic [1:0] in_opt,
  input  logic       in_clear,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_n0,
  output logic [3:0] out_n1,
  output logic [3:0] out_n2,
  output logic [3:0] out_n3,
  output logic [1:0] opt,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic       accept;
  logic       store;
  logic [3:0] digit;

  assign accept = in_valid && in_ready;

  // A clear in COLLECT abandons the frame and beats any simultaneous accept.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    store     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          store     = 1'b1;
          idx_nxt   = 2'd1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (in_clear) begin
          idx_nxt   = 2'd0;
          state_nxt = IDLE;
        end else if (accept) begin
          store   = 1'b1;
          idx_nxt = idx + 2'd1;
          if (idx == 2'd3)
            state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          idx_nxt   = 2'd0;
          state_nxt = IDLE;
        end
      end
      default: begin
        idx_nxt   = 2'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      opt       <= 2'd0;
      out_n0    <= 4'd0;
      out_n1    <= 4'd0;
      out_n2    <= 4'd0;
      out_n3    <= 4'd0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      in_ready  <= (state_nxt != HOLD);
      out_valid <= (state_nxt == HOLD);
      if (store) begin
        case (idx)
          2'd0:    out_n0 <= digit;
          2'd1:    out_n1 <= digit;
          2'd2:    out_n2 <= digit;
          default: out_n3 <= digit;
        endcase
        if (state == IDLE)
          opt <= in_opt;
      end
    end
  end

`ifdef COMC_LOADER_RANGE_CHECK_EN
  logic set_err, clear_err;

  assign digit     = (in_data > 4'd9) ? 4'd9 : in_data;
  assign set_err   = store && (in_data > 4'd9);
  assign clear_err = in_clear && (state != HOLD);

  // A fresh out-of-range digit outranks a clear issued on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (set_err)
      err <= 1'b1;
    else if (clear_err)
      err <= 1'b0;
  end
`else
  assign digit = in_data;
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_comc_loader.sv
// Self-checking bench for comc_loader: directed scenarios plus random traffic against a
// frame-level reference model (honours COMC_LOADER_RANGE_CHECK_EN like the design).
module tb_comc_loader;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_opt;
  logic       in_clear;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_n0, out_n1, out_n2, out_n3;
  logic [1:0] opt;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: digits gathered so far, whether a frame is held, and the sticky error.
  logic [3:0] m_frame [4];
  logic [1:0] m_opt;
  int         m_cnt;
  bit         m_hold;
  bit         m_err;
  int         acc_cyc [$];

  comc_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_opt    (in_opt),
    .in_clear  (in_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n0    (out_n0),
    .out_n1    (out_n1),
    .out_n2    (out_n2),
    .out_n3    (out_n3),
    .opt       (opt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_cnt  = 0;
    m_hold = 0;
    m_err  = 0;
    m_opt  = 2'd0;
    for (int i = 0; i < 4; i++) m_frame[i] = 4'd0;
    acc_cyc.delete();
  endtask

  task automatic modelEdge();
    logic [3:0] d;
    if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        m_cnt  = 0;
      end
    end else if (in_clear && m_cnt > 0) begin
      m_cnt = 0;
      m_err = 0;
    end else begin
      if (in_clear) m_err = 0;
      if (in_valid) begin
        d = in_data;
`ifdef COMC_LOADER_RANGE_CHECK_EN
        if (d > 4'd9) begin
          d     = 4'd9;
          m_err = 1;
        end
`endif
        if (m_cnt == 0) m_opt = in_opt;
        m_frame[m_cnt] = d;
        m_cnt++;
        acc_cyc.push_back(cyc);
        if (m_cnt == 4) m_hold = 1;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("in_ready", {15'd0, in_ready}, {15'd0, !m_hold});
    checkOutput("out_valid", {15'd0, out_valid}, {15'd0, m_hold});
    checkOutput("err", {15'd0, err}, {15'd0, m_err});
    if (m_hold) begin
      checkOutput("out_n0", {12'd0, out_n0}, {12'd0, m_frame[0]});
      checkOutput("out_n1", {12'd0, out_n1}, {12'd0, m_frame[1]});
      checkOutput("out_n2", {12'd0, out_n2}, {12'd0, m_frame[2]});
      checkOutput("out_n3", {12'd0, out_n3}, {12'd0, m_frame[3]});
      checkOutput("opt", {14'd0, opt}, {14'd0, m_opt});
    end
  endtask

  // Inputs change 1 time unit after an edge and are checked there too, away from the next edge.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic [1:0] o,
                               input logic clr, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_opt    = o;
    in_clear  = clr;
    out_ready = ordy;
    @(posedge clk);
    cyc++;
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("rst_err", {15'd0, err}, 16'd0);
    checkOutput("rst_opt", {14'd0, opt}, 16'd0);
    checkOutput("rst_digits", {out_n0, out_n1, out_n2, out_n3}, 16'd0);
    modelReset();
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] seq [6];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_opt    = 2'd0;
    in_clear  = 1'b0;
    out_ready = 1'b0;
    modelReset();
    #2;
    doReset();

    // Back-to-back frame with out_ready high: next accept five cycles after the first.
    seq = '{4'd3, 4'd7, 4'd1, 4'd9, 4'd8, 4'd8};
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, seq[i], 2'b01, 1'b0, 1'b1);
    checkOutput("accept_count", 16'(acc_cyc.size()), 16'd5);
    if (acc_cyc.size() >= 5)
      checkOutput("frame_period", 16'(acc_cyc[4] - acc_cyc[0]), 16'd5);
    doReset();

    // Frame held under backpressure while upstream keeps offering digits.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 2), 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'd7, 2'b11, 1'b1, 1'b0);
    checkOutput("held_accepts", 16'(acc_cyc.size()), 16'd4);
    applyStimulus(1'b0, 4'd0, 2'b00, 1'b0, 1'b1);
    doReset();

    // Clear wins over a simultaneous digit; the digit 6 must never appear.
    applyStimulus(1'b1, 4'd2, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd4, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd6, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd5, 2'b10, 1'b0, 1'b0);
    checkOutput("clear_frame", {out_n0, out_n1, out_n2, out_n3}, 16'h5555);
    applyStimulus(1'b0, 4'd0, 2'b00, 1'b0, 1'b1);

    // Asynchronous reset while holding, then an all-zero frame with opt 11.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd8, 2'b01, 1'b0, 1'b0);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd0, 2'b11, 1'b0, 1'b0);
    checkOutput("zero_frame_opt", {14'd0, opt}, 16'd3);
    applyStimulus(1'b0, 4'd0, 2'b00, 1'b0, 1'b1);

    // Out-of-range first digit; err (if enabled) survives HOLD and is cleared from IDLE.
    seq = '{4'd12, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, seq[i], 2'b10, 1'b0, 1'b0);
`ifdef COMC_LOADER_RANGE_CHECK_EN
    checkOutput("range_n0", {12'd0, out_n0}, 16'd9);
    checkOutput("range_err", {15'd0, err}, 16'd1);
`else
    checkOutput("range_n0", {12'd0, out_n0}, 16'd12);
    checkOutput("range_err", {15'd0, err}, 16'd0);
`endif
    applyStimulus(1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
    checkOutput("err_cleared", {15'd0, err}, 16'd0);

    // Op code is taken from the first digit only.
    applyStimulus(1'b1, 4'd1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd4, 2'b11, 1'b0, 1'b0);
    checkOutput("opt_first_only", {14'd0, opt}, 16'd0);
    applyStimulus(1'b0, 4'd0, 2'b00, 1'b0, 1'b1);

    // Random traffic with gaps, clears and backpressure.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comc_loader.md
COMC_LOADER -- requirements
Module: comc_loader

Interface
REQ-001 SHALL provide ports: clk  input  1  single clock, rising edge active.
REQ-002 SHALL provide: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL provide: in_valid  input  1  upstream digit valid.
REQ-004 SHALL provide: in_ready  output  1  loader can accept a digit this cycle.
REQ-005 SHALL provide: in_data  input  4  one decimal digit, nominal 0-9.
REQ-006 SHALL provide: in_opt  input  2  operation code, sampled with the first digit of a frame only.
REQ-007 SHALL provide: in_clear  input  1  synchronous abandon of the partial frame.
REQ-008 SHALL provide: out_valid  output  1  frame complete and held.
REQ-009 SHALL provide: out_ready  input  1  downstream COMC stage consumes the frame.
REQ-010 SHALL provide: out_n0, out_n1, out_n2, out_n3  output  4 each  registered digits, in arrival order.
REQ-011 SHALL provide: opt  output  2  registered operation code for the held frame.
REQ-012 SHALL provide: err  output  1  sticky range-error flag (see Configuration).

Function
REQ-013 SHALL implement states IDLE, COLLECT, HOLD, with a 2-bit digit index.
REQ-014 Digit accept SHALL occur on a rising clk edge with in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be 1 in IDLE and COLLECT and 0 in HOLD; it is a registered function of state only, with no combinational path from out_ready.
REQ-016 IDLE: on accept, SHALL store the digit in out_n0, latch in_opt into opt, set index=1, and go to COLLECT.
REQ-017 COLLECT: each accept SHALL store the digit at out_n[index] and increment index; the accept at index=3 SHALL go to HOLD and set out_valid=1 on the same edge.
REQ-018 Outputs out_n0-out_n3 and opt SHALL stay stable while out_valid=1; in_opt is ignored after the first digit.
REQ-019 HOLD: on an edge with out_ready=1, SHALL clear out_valid, reset index=0, and go to IDLE; the next digit can be accepted one cycle later.
REQ-020 Minimum frame period SHALL be 5 cycles: 4 accepts plus 1 HOLD cycle with out_ready=1.
REQ-021 in_clear=1 in COLLECT SHALL go to IDLE with index=0 and no output; clear wins over a simultaneous accept.
REQ-022 in_clear=1 in IDLE SHALL have no effect beyond clearing err.
REQ-023 in_clear=1 in HOLD SHALL be ignored; the held frame is never dropped.
REQ-024 out_n0-out_n3 contents before the first out_valid, or after a clear, are don't-care; the bench SHALL check them only while out_valid=1.
REQ-025 out_valid SHALL rise only after exactly 4 accepts since IDLE; index wrap 3->0 happens only through HOLD.

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, index=0, out_valid=0, in_ready=1 (registered), opt=0, out_n0-out_n3=0, and err=0.
REQ-027 Reset asserted mid-frame or in HOLD SHALL discard the frame; the first accept after reset release starts a new frame at out_n0.

Configuration
REQ-028 Macro COMC_LOADER_RANGE_CHECK_EN SHALL control digit range checking.
REQ-029 With the macro defined: an accepted digit above 9 SHALL be stored as 9 and SHALL set err=1 on the same edge; err stays set until rst, or until in_clear=1 in IDLE or COLLECT.
REQ-030 Without the macro: digits SHALL be stored unmodified and err SHALL be tied to 0.

Verification
REQ-031 After reset, send 3,7,1,9 with in_opt=2'b01 on consecutive cycles and out_ready=1. Required: out_valid high on the 4th accept edge; out_n0..3=3,7,1,9; opt=01; in_ready=0 for one cycle; the next accept is possible 5 cycles after the first.
REQ-032 Send one full frame and hold out_ready=0 for 10 cycles while in_valid=1. Required: no accept occurs; outputs stay stable; the frame is released on the first out_ready=1 edge.
REQ-033 Send 2,4, then pulse in_clear together with in_valid and digit 6, then send 5,5,5,5. Required: the frame is 5,5,5,5, and the digit 6 is never stored.
REQ-034 Assert rst asynchronously (no clock edge) in HOLD. Required: out_valid=0 immediately; a subsequent frame 0,0,0,0 with opt=11 outputs correctly.
REQ-035 With the macro defined, send 12,1,2,3. Required: out_n0=9 and err=1 through HOLD; a later in_clear in IDLE clears err. Without the macro: out_n0=12 and err=0.
REQ-036 Apply in_opt changes on digits 2-4 (opt 00 on the first digit, then 11). Required: output opt=00.
